// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   - aluop class encodings and R-type func codes
//   - FSM state type
//   - helper that recognises the multi-cycle multiply
package alu_seq_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SRL   = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDone
  } state_e;

  function automatic logic is_mul_op(input logic [1:0] aluop, input logic [5:0] func);
    return (aluop == ALUOP_RTYPE) && (func == FN_MUL);
  endfunction

endpackage

// File: rtl/mul_shift_add_iter.sv
// Iterative shift-add multiplier datapath (one partial product per step).
//   clk, rst : clock, synchronous active-high reset (clears all state)
//   start    : load a/b, clear accumulator and counter
//   step     : perform one iteration
//   a, b     : operands, sampled on start
//   done     : the iteration performed this cycle is the last one
//   product  : accumulator, low WIDTH bits of a*b once done has been seen
// Optional macro ALU_SEQ_EARLY_TERM_EN: finish as soon as no multiplier bits remain.
module mul_shift_add_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CntW-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
    end
  end

  always_comb begin
`ifdef ALU_SEQ_EARLY_TERM_EN
    // Once the bits above bit 0 are zero, this step contributes the final partial product.
    done = (cnt_q == CntW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    done = (cnt_q == CntW'(WIDTH - 1));
`endif
  end

  assign product = acc_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// EX-stage ALU sequencer: one op per req handshake, registered result.
// Single-cycle ops (add/sub/sll/srl/illegal) return one cycle after accept;
// MUL iterates in mul_shift_add_iter while stall/busy hold the pipeline.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only in idle, not in reset)
//   a, b, aluop, func    : operands and decode fields
//   res_valid/res        : result pulse / held result
//   illegal_op           : pulses with res_valid for unsupported decodes
//   stall, busy          : high while a multiply is in flight (incl. result cycle)
// Optional macro ALU_SEQ_EARLY_TERM_EN: multiply finishes early on small multipliers.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       aluop,
  input  logic [5:0]       func,
  output logic             res_valid,
  output logic [WIDTH-1:0] res,
  output logic             illegal_op,
  output logic             stall,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q;
  logic             res_valid_q, illegal_q;

  logic             accept;
  logic             op_mul, op_ill;
  logic [WIDTH-1:0] op_res;
  logic [SHAMT_W-1:0] shamt;

  logic             mul_start, mul_step, mul_done;
  logic [WIDTH-1:0] mul_product;

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;
  assign shamt     = b[SHAMT_W-1:0];

  // Decode and single-cycle datapath
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    op_mul = is_mul_op(aluop, func);
    case (aluop)
      ALUOP_ADD: op_res = a + b;
      ALUOP_SRL: op_res = a >> shamt;
      ALUOP_RTYPE: begin
        case (func)
          FN_ADD:  op_res = a + b;
          FN_SUB:  op_res = a - b;
          FN_SLL:  op_res = a << shamt;
          FN_SRL:  op_res = a >> shamt;
          FN_MUL:  op_res = '0;
          default: op_ill = 1'b1;
        endcase
      end
      default: op_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept && op_mul) begin
          mul_start = 1'b1;
          state_d   = StMul;
        end
      end
      StMul: begin
        mul_step = 1'b1;
        if (mul_done) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= accept && !op_mul;
      illegal_q   <= accept && !op_mul && op_ill;
      if (accept && !op_mul) begin
        res_q <= op_res;
      end else if (state_q == StDone) begin
        // Capture the product so res keeps it after the DONE cycle.
        res_q <= mul_product;
      end
    end
  end

  mul_shift_add_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .step   (mul_step),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_product)
  );

  assign busy  = (state_q != StIdle);
  assign stall = busy;

  // Gating with rst keeps result pulses out of reset cycles.
  assign res_valid  = !rst && (res_valid_q || (state_q == StDone));
  assign illegal_op = !rst && illegal_q;
  assign res        = (state_q == StDone) ? mul_product : res_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready;
  logic [31:0] a, b, res;
  logic [1:0]  aluop;
  logic [5:0]  func;
  logic        res_valid, illegal_op, stall, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mul_acc = -1;
  int mul_end = -1;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  alu_op_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .aluop     (aluop),
    .func      (func),
    .res_valid (res_valid),
    .res       (res),
    .illegal_op(illegal_op),
    .stall     (stall),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mul_lat(input logic [31:0] bv);
`ifdef ALU_SEQ_EARLY_TERM_EN
    int h = -1;
    for (int i = 0; i < 32; i++) if (bv[i]) h = i;
    return (h < 0) ? 2 : h + 2;
`else
    return 33;
`endif
  endfunction

  // Monitor: handshake/stall window from bench state, results from the scoreboard.
  always @(negedge clk) begin
    logic bexp;
    bexp = (cyc > mul_acc) && (cyc <= mul_end);
    check("busy", {31'b0, busy}, {31'b0, bexp});
    check("stall", {31'b0, stall}, {31'b0, bexp});
    check("req_ready", {31'b0, req_ready}, {31'b0, !rst && !bexp});
    if (res_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("res", res, e.res);
        check("illegal_op", {31'b0, illegal_op}, {31'b0, e.ill});
        check("res_cycle", cyc, e.cyc);
        last_res = e.res;
      end
    end else begin
      check("illegal_no_valid", {31'b0, illegal_op}, 32'd0);
      if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        check("missing_res_valid", cyc, 32'(sbq[0].cyc) - 32'd1);
        void'(sbq.pop_front());
      end
    end
  end

  // Drives one request for one cycle (caller is at posedge+1).
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] er, input logic ei,
                       input int lat);
    exp_t e;
    req_valid = 1'b1;
    aluop = op; func = fn; a = av; b = bv;
    e.res = er; e.ill = ei; e.cyc = cyc + lat;
    sbq.push_back(e);
    if (lat > 1) begin
      mul_acc = cyc;
      mul_end = cyc + lat;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sbq.size(), 0);
  endtask

  initial begin
    logic [31:0] ra, rb, re;
    logic [5:0]  fn;
    rst = 1'b1; req_valid = 1'b0; a = '0; b = '0; aluop = '0; func = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_res", res, 32'd0);
    check("reset_valid", {31'b0, res_valid}, 32'd0);
    @(posedge clk); #1;

    // Single-cycle ops
    issue(ALUOP_RTYPE, FN_ADD, 32'd7, 32'd5, 32'd12, 1'b0, 1);
    issue(ALUOP_RTYPE, FN_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
    drain();

    // Back-to-back add then srl (shamt = 0x21 & 31 = 1)
    issue(ALUOP_RTYPE, FN_ADD, 32'd7, 32'd5, 32'd12, 1'b0, 1);
    issue(ALUOP_SRL, 6'b000000, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 1);
    drain();
    check("res_hold", res, last_res);

    // Illegal decodes
    issue(2'b01, FN_ADD, 32'd9, 32'd9, 32'd0, 1'b1, 1);
    issue(ALUOP_RTYPE, 6'b111111, 32'd9, 32'd9, 32'd0, 1'b1, 1);
    drain();

    // Multiply, with a request attempted while busy (must be ignored)
    issue(ALUOP_RTYPE, FN_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0,
          mul_lat(32'h0002_0005));
    @(posedge clk); #1;
    req_valid = 1'b1; aluop = ALUOP_ADD; a = 32'd1; b = 32'd1;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
    check("mul_hold", res, 32'h000B_000F);

    // Short multipliers (early-terminating when enabled)
    issue(ALUOP_RTYPE, FN_MUL, 32'd6, 32'd5, 32'd30, 1'b0, mul_lat(32'd5));
    drain();
    issue(ALUOP_RTYPE, FN_MUL, 32'h1234_5678, 32'd0, 32'd0, 1'b0, mul_lat(32'd0));
    drain();
    ra = 32'hFFFF_FFFF; rb = 32'h8000_0001; re = ra * rb;
    issue(ALUOP_RTYPE, FN_MUL, ra, rb, re, 1'b0, mul_lat(rb));
    drain();

    // Random single-cycle ops
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      case (i % 5)
        0: issue(ALUOP_ADD, 6'($urandom), ra, rb, ra + rb, 1'b0, 1);
        1: issue(ALUOP_RTYPE, FN_SUB, ra, rb, ra - rb, 1'b0, 1);
        2: issue(ALUOP_RTYPE, FN_SLL, ra, rb, ra << rb[4:0], 1'b0, 1);
        3: issue(ALUOP_RTYPE, FN_SRL, ra, rb, ra >> rb[4:0], 1'b0, 1);
        default: begin
          fn = 6'($urandom);
          issue(ALUOP_SRL, fn, ra, rb, ra >> rb[4:0], 1'b0, 1);
        end
      endcase
    end
    drain();

    // Reset in the middle of a multiply
    issue(ALUOP_RTYPE, FN_MUL, 32'd1000, 32'hFFFF_FFFF, 32'd1000 * 32'hFFFF_FFFF, 1'b0,
          mul_lat(32'hFFFF_FFFF));
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    mul_end = cyc;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_res", res, 32'd0);
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    issue(ALUOP_RTYPE, FN_ADD, 32'd40, 32'd2, 32'd42, 1'b0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
